// File: rtl/i2c_target_responder_pkg.sv
// Shared definitions for the I2C target responder.
//   i2c_state_e : target FSM states
//   bus_cond_e  : bus-condition codes, also used as bit positions of the
//                 per-cycle event vector in the top level
//   BYTE_W      : bits per I2C byte
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    WAIT_STOP
  } i2c_state_e;

  typedef enum logic [1:0] {
    START,
    STOP,
    RISE,
    FALL
  } bus_cond_e;

endpackage

// File: rtl/i2c_target_responder_in_filter.sv
// Pad input conditioning for one I2C line: 2-flop synchronizer, glitch
// filter and edge detect.
//   wb_clk_i : system clock
//   arst_i   : asynchronous reset, active low (all stages preset to 1)
//   pad_i    : raw pad level
//   level_o  : filtered level; changes after FILT_LEN consecutive equal
//              samples that differ from the current level
//   rise_o   : one-cycle pulse, the cycle after level_o rises
//   fall_o   : one-cycle pulse, the cycle after level_o falls
module i2c_in_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic wb_clk_i,
  input  logic arst_i,
  input  logic pad_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync;
  logic [3:0] cnt;
  logic       level;
  logic       level_d;

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      sync    <= '1;
      cnt     <= '0;
      level   <= 1'b1;
      level_d <= 1'b1;
    end else begin
      sync    <= {sync[0], pad_i};
      level_d <= level;
      if (sync[1] != level) begin
        if (cnt == 4'(FILT_LEN - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 4'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign level_o = level;
  assign rise_o  = level & ~level_d;
  assign fall_o  = ~level & level_d;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target responder on open-drain SCL/SDA pads (SCL never driven).
// Decodes START/Sr/STOP, ACKs SLV_ADDR, accepts a byte-pointer write then
// data writes, or serves reads with pointer auto-increment.
//   wb_clk_i     : system clock
//   arst_i       : asynchronous reset, active low
//   scl_pad_i    : SCL pad input
//   sda_pad_i    : SDA pad input
//   sda_pad_o    : SDA output value, tied 0
//   sda_padoen_o : SDA output enable, active low (0 = pull low)
//   reg_addr_o   : local register byte pointer
//   reg_wr_o     : one-cycle write strobe, reg_wdat_o valid with it
//   reg_wdat_o   : write data
//   reg_rd_o     : one-cycle read strobe
//   reg_rdat_i   : read data, sampled the cycle after reg_rd_o
//   busy_o       : high from START until STOP
module i2c_target_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLV_ADDR = 7'h50,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       scl_pad_i,
  input  logic       sda_pad_i,
  output logic       sda_pad_o,
  output logic       sda_padoen_o,
  output logic [7:0] reg_addr_o,
  output logic       reg_wr_o,
  output logic [7:0] reg_wdat_o,
  output logic       reg_rd_o,
  input  logic [7:0] reg_rdat_i,
  output logic       busy_o
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .wb_clk_i (wb_clk_i),
    .arst_i   (arst_i),
    .pad_i    (scl_pad_i),
    .level_o  (scl_lvl),
    .rise_o   (scl_rise),
    .fall_o   (scl_fall)
  );

  i2c_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .wb_clk_i (wb_clk_i),
    .arst_i   (arst_i),
    .pad_i    (sda_pad_i),
    .level_o  (sda_lvl),
    .rise_o   (sda_rise),
    .fall_o   (sda_fall)
  );

  logic [3:0] ev;
  always_comb begin
    ev        = '0;
    ev[START] = sda_fall & scl_lvl;
    ev[STOP]  = sda_rise & scl_lvl;
    ev[RISE]  = scl_rise;
    ev[FALL]  = scl_fall;
  end

  i2c_state_e state;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] rx_byte;
  logic       rw;
  logic       ack_drv;   // second scl_fall of an ACK slot ends it
  logic       rd_cap;    // read data is valid this cycle
  logic       sda_oen;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdat;
  logic       reg_wr;
  logic       reg_rd;
  logic       busy;

  assign rx_byte = {shreg[6:0], sda_lvl};

  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      rw       <= 1'b0;
      ack_drv  <= 1'b0;
      rd_cap   <= 1'b0;
      sda_oen  <= 1'b1;
      reg_addr <= '0;
      reg_wdat <= '0;
      reg_wr   <= 1'b0;
      reg_rd   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      rd_cap <= reg_rd;
      if (rd_cap) shreg <= reg_rdat_i;

      if (ev[START]) begin
        state   <= ADDR;
        bit_cnt <= '0;
        sda_oen <= 1'b1;
        busy    <= 1'b1;
      end else if (ev[STOP]) begin
        state   <= IDLE;
        sda_oen <= 1'b1;
        busy    <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (ev[RISE]) begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'(BYTE_W - 1)) begin
                bit_cnt <= '0;
                ack_drv <= 1'b0;
                case (state)
                  ADDR: begin
                    if (rx_byte[7:1] == SLV_ADDR) begin
                      rw    <= rx_byte[0];
                      state <= ADDR_ACK;
                    end else begin
                      state <= WAIT_STOP;
                    end
                  end
                  PTR: begin
                    reg_addr <= rx_byte;
                    state    <= PTR_ACK;
                  end
                  default: begin
                    reg_wr   <= 1'b1;
                    reg_wdat <= rx_byte;
                    state    <= WDATA_ACK;
                  end
                endcase
              end
            end
          end

          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (ev[FALL]) begin
              if (!ack_drv) begin
                ack_drv <= 1'b1;
                sda_oen <= 1'b0;
                // Fetch early so the byte is loaded well before the
                // ACK-ending fall presents its MSB.
                if (state == ADDR_ACK && rw) reg_rd <= 1'b1;
              end else begin
                ack_drv <= 1'b0;
                bit_cnt <= '0;
                sda_oen <= 1'b1;
                case (state)
                  ADDR_ACK: begin
                    if (rw) begin
                      sda_oen <= shreg[7];
                      shreg   <= {shreg[6:0], 1'b0};
                      bit_cnt <= 4'd1;
                      state   <= RDATA;
                    end else begin
                      state <= PTR;
                    end
                  end
                  PTR_ACK: state <= WDATA;
                  default: begin
                    reg_addr <= reg_addr + 8'd1;
                    state    <= WDATA;
                  end
                endcase
              end
            end
          end

          RDATA: begin
            if (ev[FALL]) begin
              if (bit_cnt == 4'(BYTE_W)) begin
                sda_oen <= 1'b1;
                state   <= RACK;
              end else begin
                sda_oen <= shreg[7];
                shreg   <= {shreg[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end

          RACK: begin
            if (ev[RISE]) begin
              if (!sda_lvl) begin
                reg_addr <= reg_addr + 8'd1;
                reg_rd   <= 1'b1;
                bit_cnt  <= '0;
                state    <= RDATA;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = sda_oen;
  assign reg_addr_o   = reg_addr;
  assign reg_wr_o     = reg_wr;
  assign reg_wdat_o   = reg_wdat;
  assign reg_rd_o     = reg_rd;
  assign busy_o       = busy;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Bench for i2c_target_responder: behavioural I2C master on a wired-AND
// SDA line, scoreboard for the local register port strobes.
module tb_i2c_target_responder;
  import i2c_pkg::*;

  localparam int Q = 10;   // quarter SCL period in system clocks

  logic       clk = 1'b0;
  logic       arst_i;
  logic       scl_m, sda_m;
  logic       sda_bus;
  logic       sda_pad_o, sda_padoen_o;
  logic [7:0] reg_addr_o, reg_wdat_o, reg_rdat_i;
  logic       reg_wr_o, reg_rd_o, busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & (sda_padoen_o | sda_pad_o);

  i2c_target_responder #(.SLV_ADDR(7'h50), .FILT_LEN(3)) dut (
    .wb_clk_i     (clk),
    .arst_i       (arst_i),
    .scl_pad_i    (scl_m),
    .sda_pad_i    (sda_bus),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .reg_addr_o   (reg_addr_o),
    .reg_wr_o     (reg_wr_o),
    .reg_wdat_o   (reg_wdat_o),
    .reg_rd_o     (reg_rd_o),
    .reg_rdat_i   (reg_rdat_i),
    .busy_o       (busy_o)
  );

  // Local register file model: data valid the cycle after the read strobe.
  logic [7:0] mem [256];
  always @(posedge clk) if (reg_rd_o) reg_rdat_i <= mem[reg_addr_o];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected write {addr,data} and read addresses.
  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic        wr_d = 1'b0, rd_d = 1'b0;
  logic        no_drive = 1'b0;
  int          drive_viol = 0;

  always @(negedge clk) begin : monitor
    logic [15:0] ew;
    logic [7:0]  er;
    if (arst_i === 1'b1) begin
      if (reg_wr_o) begin
        if (wr_d) begin
          total++; bad++;
          $display("FAIL wr_width: strobe high 2+ cycles, required 1");
        end else if (exp_wr_q.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected: addr=%0h data=%0h, required no write", reg_addr_o, reg_wdat_o);
        end else begin
          ew = exp_wr_q.pop_front();
          chk("wr_addr_data", {16'h0, reg_addr_o, reg_wdat_o}, {16'h0, ew});
        end
      end
      if (reg_rd_o) begin
        if (rd_d) begin
          total++; bad++;
          $display("FAIL rd_width: strobe high 2+ cycles, required 1");
        end else if (exp_rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: addr=%0h, required no read", reg_addr_o);
        end else begin
          er = exp_rd_q.pop_front();
          chk("rd_addr", {24'h0, reg_addr_o}, {24'h0, er});
        end
      end
      if (no_drive && !sda_padoen_o) drive_viol++;
    end
    wr_d = reg_wr_o;
    rd_d = reg_rd_o;
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(Q);
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; clks(Q);
    scl_m = 1'b1; clks(Q);
    sda_m = 1'b1; clks(Q);
  endtask

  task automatic put_bit(input logic b, input logic glitch);
    sda_m = b; clks(Q);
    scl_m = 1'b1; clks(Q / 2);
    if (glitch) begin
      scl_m = 1'b0; clks(2);
      scl_m = 1'b1;
    end
    clks(Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; clks(Q);
    scl_m = 1'b1; clks(Q);
    b = sda_bus; clks(Q);
    scl_m = 1'b0; clks(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i], i == glitch_bit);
    get_bit(ack);
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(ack, 1'b0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic       ack;
    logic [7:0] d;
    int         n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[2] = 8'h3C;
    mem[3] = 8'hC3;
    arst_i = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    clks(3);
    chk("rst_oen",  {31'h0, sda_padoen_o}, 32'h1);
    chk("rst_busy", {31'h0, busy_o}, 32'h0);
    chk("rst_addr", {24'h0, reg_addr_o}, 32'h0);
    chk("rst_wdat", {24'h0, reg_wdat_o}, 32'h0);
    chk("rst_strb", {30'h0, reg_wr_o, reg_rd_o}, 32'h0);
    arst_i = 1'b1;
    clks(10);

    // Write 0x5A to 0x03.
    exp_wr_q.push_back(16'h035A);
    i2c_start();
    chk("wr_busy_hi", {31'h0, busy_o}, 32'h1);
    wr_byte(8'hA0, -1, ack); chk("wr_ack_addr", {31'h0, ack}, 32'h0);
    wr_byte(8'h03, -1, ack); chk("wr_ack_ptr",  {31'h0, ack}, 32'h0);
    wr_byte(8'h5A, -1, ack); chk("wr_ack_data", {31'h0, ack}, 32'h0);
    i2c_stop(); clks(Q);
    chk("wr_busy_lo", {31'h0, busy_o}, 32'h0);

    // Address mismatch: never ACKed, no strobes.
    no_drive = 1'b1;
    i2c_start();
    wr_byte(8'hA2, -1, ack); chk("mm_nack_addr", {31'h0, ack}, 32'h1);
    wr_byte(8'h11, -1, ack); chk("mm_nack_data", {31'h0, ack}, 32'h1);
    chk("mm_state", 32'(dut.state), 32'(WAIT_STOP));
    chk("mm_busy",  {31'h0, busy_o}, 32'h1);
    i2c_stop(); clks(Q);
    chk("mm_state_idle", 32'(dut.state), 32'(IDLE));
    no_drive = 1'b0;
    chk("mm_sda_driven", 32'(drive_viol), 32'h0);

    // Random read: pointer 0x02, Sr, read 0x3C (ACK) then 0xC3 (NACK).
    exp_rd_q.push_back(8'h02);
    exp_rd_q.push_back(8'h03);
    i2c_start();
    wr_byte(8'hA0, -1, ack); chk("rd_ack_addrw", {31'h0, ack}, 32'h0);
    wr_byte(8'h02, -1, ack); chk("rd_ack_ptr",   {31'h0, ack}, 32'h0);
    i2c_start();
    wr_byte(8'hA1, -1, ack); chk("rd_ack_addrr", {31'h0, ack}, 32'h0);
    rd_byte(1'b0, d); chk("rd_byte0", {24'h0, d}, 32'h3C);
    rd_byte(1'b1, d); chk("rd_byte1", {24'h0, d}, 32'hC3);
    clks(2);
    chk("rd_release", {31'h0, sda_padoen_o}, 32'h1);
    i2c_stop(); clks(Q);

    // Pointer wrap.
    exp_wr_q.push_back(16'hFF11);
    exp_wr_q.push_back(16'h0022);
    i2c_start();
    wr_byte(8'hA0, -1, ack); chk("wrap_ack_addr", {31'h0, ack}, 32'h0);
    wr_byte(8'hFF, -1, ack); chk("wrap_ack_ptr",  {31'h0, ack}, 32'h0);
    wr_byte(8'h11, -1, ack); chk("wrap_ack_d0",   {31'h0, ack}, 32'h0);
    wr_byte(8'h22, -1, ack); chk("wrap_ack_d1",   {31'h0, ack}, 32'h0);
    i2c_stop(); clks(Q);

    // 2-cycle SCL glitches inside bytes must not count as clocks.
    exp_wr_q.push_back(16'h0799);
    i2c_start();
    wr_byte(8'hA0, 4, ack);  chk("gl_ack_addr", {31'h0, ack}, 32'h0);
    wr_byte(8'h07, 0, ack);  chk("gl_ack_ptr",  {31'h0, ack}, 32'h0);
    wr_byte(8'h99, 3, ack);  chk("gl_ack_data", {31'h0, ack}, 32'h0);
    i2c_stop(); clks(Q);

    // Reset while the target is pulling SDA low for an ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) put_bit(1'(8'hA0 >> i), 1'b0);
    sda_m = 1'b1;
    n = 0;
    while (sda_padoen_o && n < 100) begin
      clks(1);
      n++;
    end
    chk("rstack_drive_seen", {31'h0, sda_padoen_o}, 32'h0);
    arst_i = 1'b0;
    #1;
    chk("rstack_oen",   {31'h0, sda_padoen_o}, 32'h1);
    chk("rstack_busy",  {31'h0, busy_o}, 32'h0);
    chk("rstack_state", 32'(dut.state), 32'(IDLE));
    clks(2);
    scl_m = 1'b1; sda_m = 1'b1;
    clks(5);
    arst_i = 1'b1;
    clks(20);
    i2c_start();
    wr_byte(8'hA0, -1, ack); chk("rstack_reack", {31'h0, ack}, 32'h0);
    i2c_stop(); clks(Q);

    chk("sb_wr_left", 32'(exp_wr_q.size()), 32'h0);
    chk("sb_rd_left", 32'(exp_rd_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
